// File: rtl/booth_mac_accum_if.sv
// Product-in / frame-total-out handshake bundle for booth_mac_accum.
// master is the surrounding logic (producer + consumer), slave is the accumulator.
interface booth_mac_accum_if #(
  parameter int unsigned ACC_W = 24
);
  logic signed [15:0]      prod;
  logic                    in_valid;
  logic                    in_ready;
  logic                    clr;
  logic signed [ACC_W-1:0] acc_out;
  logic                    ovf_out;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output prod, in_valid, clr, out_ready,
    input  in_ready, acc_out, ovf_out, out_valid
  );

  modport slave (
    input  prod, in_valid, clr, out_ready,
    output in_ready, acc_out, ovf_out, out_valid
  );
endinterface

// File: rtl/booth_mac_accum.sv
// Accumulates frames of NTERMS signed 16-bit products into a wide, optionally saturating
// accumulator and presents each frame total on a valid/ready output.
module booth_mac_accum #(
  parameter int unsigned ACC_W    = 24,
  parameter int unsigned NTERMS   = 4,
  parameter int unsigned SATURATE = 1
) (
  input logic              clk,
  input logic              rst_n,
  booth_mac_accum_if.slave bus
);
  localparam int unsigned CntW = (NTERMS > 1) ? $clog2(NTERMS) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(NTERMS - 1);

  localparam logic StAcc  = 1'b0;
  localparam logic StHold = 1'b1;

  localparam logic signed [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

  logic                    state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;
  logic signed [ACC_W-1:0] acc_out_q, acc_out_d;
  logic                    ovf_out_q, ovf_out_d;
  logic                    out_valid_q, out_valid_d;

  logic                    accept;
  logic signed [ACC_W-1:0] acc_base;
  logic [CntW-1:0]         cnt_base;
  logic                    ovf_base;
  logic signed [ACC_W:0]   sum;
  logic                    step_ovf;
  logic signed [ACC_W-1:0] step_res;

  assign accept = bus.in_valid && (state_q == StAcc);

  // clr restarts the frame, so an accept in the same cycle becomes term 1.
  assign acc_base = bus.clr ? '0 : acc_q;
  assign cnt_base = bus.clr ? '0 : cnt_q;
  assign ovf_base = bus.clr ? 1'b0 : ovf_q;

  assign sum      = {acc_base[ACC_W-1], acc_base} + {{(ACC_W+1-16){bus.prod[15]}}, bus.prod};
  assign step_ovf = sum[ACC_W] != sum[ACC_W-1];

  always_comb begin
    step_res = sum[ACC_W-1:0];
    if (step_ovf && (SATURATE != 0)) begin
      step_res = sum[ACC_W] ? AccMin : AccMax;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    acc_out_d   = acc_out_q;
    ovf_out_d   = ovf_out_q;
    out_valid_d = out_valid_q;
    if (state_q == StAcc) begin
      if (bus.clr) begin
        acc_d = '0;
        cnt_d = '0;
        ovf_d = 1'b0;
      end
      if (accept) begin
        if (cnt_base == CntLast) begin
          acc_out_d   = step_res;
          ovf_out_d   = ovf_base | step_ovf;
          out_valid_d = 1'b1;
          state_d     = StHold;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
        end else begin
          acc_d = step_res;
          cnt_d = cnt_base + CntW'(1);
          ovf_d = ovf_base | step_ovf;
        end
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
      state_d     = StAcc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StAcc;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      acc_out_q   <= '0;
      ovf_out_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      acc_out_q   <= acc_out_d;
      ovf_out_q   <= ovf_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == StAcc);
  assign bus.acc_out   = acc_out_q;
  assign bus.ovf_out   = ovf_out_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_booth_mac_accum.sv
// Directed bench for booth_mac_accum: a 24-bit saturating unit plus 16-bit saturating
// and 16-bit wrapping units sharing one clock and reset.
module tb_booth_mac_accum;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  booth_mac_accum_if #(.ACC_W(24)) b24 ();
  booth_mac_accum_if #(.ACC_W(16)) b16s ();
  booth_mac_accum_if #(.ACC_W(16)) b16w ();

  booth_mac_accum #(.ACC_W(24), .NTERMS(4), .SATURATE(1)) u_acc24 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b24)
  );

  booth_mac_accum #(.ACC_W(16), .NTERMS(4), .SATURATE(1)) u_acc16s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b16s)
  );

  booth_mac_accum #(.ACC_W(16), .NTERMS(4), .SATURATE(0)) u_acc16w (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b16w)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of in_valid=1 with prod p on unit u (0: 24-bit, 1: 16-bit sat, 2: 16-bit wrap).
  task automatic feed(input int u, input logic signed [15:0] p);
    case (u)
      0: begin b24.prod = p;  b24.in_valid = 1'b1;  end
      1: begin b16s.prod = p; b16s.in_valid = 1'b1; end
      default: begin b16w.prod = p; b16w.in_valid = 1'b1; end
    endcase
    tick();
    b24.in_valid  = 1'b0;
    b16s.in_valid = 1'b0;
    b16w.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (b24.acc_out !== 24'sd0 || b24.out_valid !== 1'b0 || b24.ovf_out !== 1'b0
        || b24.in_ready !== 1'b1) begin
      $display("FAIL reset_state got acc=%0d ovf=%b vld=%b rdy=%b exp acc=0 ovf=0 vld=0 rdy=1",
               b24.acc_out, b24.ovf_out, b24.out_valid, b24.in_ready);
      failures++;
    end
    #10 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (b24.acc_out !== 24'sd0 || b24.out_valid !== 1'b0 || b24.in_ready !== 1'b1
          || b16s.out_valid !== 1'b0) begin
        $display("FAIL idle_cycle%0d got acc=%0d vld=%b rdy=%b exp acc=0 vld=0 rdy=1",
                 i, b24.acc_out, b24.out_valid, b24.in_ready);
        failures++;
      end
    end
  endtask

  task automatic test_basic_frame();
    b24.out_ready = 1'b1;
    feed(0, 16'sd100);
    feed(0, -16'sd50);
    feed(0, 16'sd16384);
    checks++;
    if (b24.out_valid !== 1'b0) begin
      $display("FAIL basic_early_valid got vld=%b exp vld=0", b24.out_valid);
      failures++;
    end
    feed(0, -16'sd16256);
    checks++;
    if (b24.acc_out !== 24'sd178 || b24.ovf_out !== 1'b0 || b24.out_valid !== 1'b1
        || b24.in_ready !== 1'b0) begin
      $display("FAIL basic_result got acc=%0d ovf=%b vld=%b rdy=%b exp acc=178 ovf=0 vld=1 rdy=0",
               b24.acc_out, b24.ovf_out, b24.out_valid, b24.in_ready);
      failures++;
    end
    tick();
    checks++;
    if (b24.out_valid !== 1'b0 || b24.in_ready !== 1'b1 || b24.acc_out !== 24'sd178) begin
      $display("FAIL basic_one_cycle got vld=%b rdy=%b acc=%0d exp vld=0 rdy=1 acc=178",
               b24.out_valid, b24.in_ready, b24.acc_out);
      failures++;
    end
  endtask

  task automatic test_backpressure();
    b24.out_ready = 1'b0;
    feed(0, 16'sd100);
    feed(0, -16'sd50);
    feed(0, 16'sd16384);
    feed(0, -16'sd16256);
    b24.prod     = 16'sd5;
    b24.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (b24.acc_out !== 24'sd178 || b24.out_valid !== 1'b1 || b24.in_ready !== 1'b0) begin
        $display("FAIL bp_hold%0d got acc=%0d vld=%b rdy=%b exp acc=178 vld=1 rdy=0",
                 i, b24.acc_out, b24.out_valid, b24.in_ready);
        failures++;
      end
      tick();
    end
    b24.in_valid  = 1'b0;
    b24.out_ready = 1'b1;
    tick();
    checks++;
    if (b24.out_valid !== 1'b0 || b24.in_ready !== 1'b1) begin
      $display("FAIL bp_release got vld=%b rdy=%b exp vld=0 rdy=1", b24.out_valid, b24.in_ready);
      failures++;
    end
    for (int i = 0; i < 4; i++) feed(0, 16'sd5);
    checks++;
    if (b24.acc_out !== 24'sd20 || b24.ovf_out !== 1'b0 || b24.out_valid !== 1'b1) begin
      $display("FAIL bp_next_frame got acc=%0d ovf=%b vld=%b exp acc=20 ovf=0 vld=1",
               b24.acc_out, b24.ovf_out, b24.out_valid);
      failures++;
    end
    tick();
  endtask

  task automatic test_saturation();
    b16s.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) feed(1, 16'sd16384);
    checks++;
    if (b16s.acc_out !== 16'sd32767 || b16s.ovf_out !== 1'b1 || b16s.out_valid !== 1'b1) begin
      $display("FAIL sat_pos got acc=%0d ovf=%b vld=%b exp acc=32767 ovf=1 vld=1",
               b16s.acc_out, b16s.ovf_out, b16s.out_valid);
      failures++;
    end
    tick();
    for (int i = 0; i < 4; i++) feed(1, -16'sd16256);
    checks++;
    if (b16s.acc_out !== 16'sh8000 || b16s.ovf_out !== 1'b1) begin
      $display("FAIL sat_neg got acc=%0d ovf=%b exp acc=-32768 ovf=1",
               b16s.acc_out, b16s.ovf_out);
      failures++;
    end
    tick();
    for (int i = 1; i <= 4; i++) feed(1, 16'(i));
    checks++;
    if (b16s.acc_out !== 16'sd10 || b16s.ovf_out !== 1'b0) begin
      $display("FAIL sat_sticky_clear got acc=%0d ovf=%b exp acc=10 ovf=0",
               b16s.acc_out, b16s.ovf_out);
      failures++;
    end
    tick();
  endtask

  task automatic test_wrap();
    b16w.out_ready = 1'b1;
    feed(2, 16'sd16384);
    feed(2, 16'sd16384);
    feed(2, 16'sd0);
    feed(2, 16'sd0);
    checks++;
    if (b16w.acc_out !== 16'sh8000 || b16w.ovf_out !== 1'b1 || b16w.out_valid !== 1'b1) begin
      $display("FAIL wrap got acc=%0d ovf=%b vld=%b exp acc=-32768 ovf=1 vld=1",
               b16w.acc_out, b16w.ovf_out, b16w.out_valid);
      failures++;
    end
    tick();
  endtask

  task automatic test_clr();
    b24.out_ready = 1'b1;
    feed(0, 16'sd9);
    feed(0, 16'sd9);
    b24.clr = 1'b1;
    feed(0, 16'sd7);
    b24.clr = 1'b0;
    feed(0, 16'sd1);
    feed(0, 16'sd1);
    checks++;
    if (b24.out_valid !== 1'b0) begin
      $display("FAIL clr_accept_count got vld=%b exp vld=0", b24.out_valid);
      failures++;
    end
    feed(0, 16'sd1);
    checks++;
    if (b24.acc_out !== 24'sd10 || b24.out_valid !== 1'b1) begin
      $display("FAIL clr_accept got acc=%0d vld=%b exp acc=10 vld=1", b24.acc_out, b24.out_valid);
      failures++;
    end
    tick();
    feed(0, 16'sd50);
    b24.clr = 1'b1;
    tick();
    b24.clr = 1'b0;
    for (int i = 1; i <= 4; i++) feed(0, 16'(i));
    checks++;
    if (b24.acc_out !== 24'sd10 || b24.ovf_out !== 1'b0 || b24.out_valid !== 1'b1) begin
      $display("FAIL clr_only got acc=%0d ovf=%b vld=%b exp acc=10 ovf=0 vld=1",
               b24.acc_out, b24.ovf_out, b24.out_valid);
      failures++;
    end
    tick();
  endtask

  task automatic test_async_reset();
    feed(0, 16'sd9);
    feed(0, 16'sd9);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (b24.acc_out !== 24'sd0 || b24.ovf_out !== 1'b0 || b24.out_valid !== 1'b0
        || b24.in_ready !== 1'b1) begin
      $display("FAIL rst_midframe got acc=%0d ovf=%b vld=%b rdy=%b exp acc=0 ovf=0 vld=0 rdy=1",
               b24.acc_out, b24.ovf_out, b24.out_valid, b24.in_ready);
      failures++;
    end
    #2 rst_n = 1'b1;
    tick();
    b24.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) feed(0, 16'sd1);
    checks++;
    if (b24.acc_out !== 24'sd4 || b24.out_valid !== 1'b1) begin
      $display("FAIL rst_discard got acc=%0d vld=%b exp acc=4 vld=1", b24.acc_out, b24.out_valid);
      failures++;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (b24.out_valid !== 1'b0 || b24.in_ready !== 1'b1 || b24.acc_out !== 24'sd0) begin
      $display("FAIL rst_in_hold got vld=%b rdy=%b acc=%0d exp vld=0 rdy=1 acc=0",
               b24.out_valid, b24.in_ready, b24.acc_out);
      failures++;
    end
    #2 rst_n = 1'b1;
    tick();
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    b24.prod       = '0;
    b24.in_valid   = 1'b0;
    b24.clr        = 1'b0;
    b24.out_ready  = 1'b0;
    b16s.prod      = '0;
    b16s.in_valid  = 1'b0;
    b16s.clr       = 1'b0;
    b16s.out_ready = 1'b0;
    b16w.prod      = '0;
    b16w.in_valid  = 1'b0;
    b16w.clr       = 1'b0;
    b16w.out_ready = 1'b0;
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_saturation();
    test_wrap();
    test_clr();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
